// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI4 burst slave memory.
// Holds the burst and response encodings, the write/read FSM state
// types and the size-to-byte-count helper. There are no ports; the
// other rtl files import this package.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic [7:0] bytes_from_size(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address step and legality check.
// Ports:
//   addr      in  ADDR_W  current beat byte address
//   len       in  8       beats minus one
//   size      in  3       log2 bytes per beat
//   burst     in  2       FIXED / INCR / WRAP / reserved
//   next_addr out ADDR_W  address of the following beat
//   illegal   out 1       transaction cannot be served (size, burst or wrap length)
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRB_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              illegal
);

    localparam int LANE_W = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] wrap_mask;
    burst_t            btype;

    always_comb begin
        btype     = burst_t'(burst);
        bytes     = ADDR_W'(bytes_from_size(size));
        aligned   = addr & ~(bytes - ONE);
        // Wrap boundary is the total burst length in bytes; it is a power
        // of two whenever the wrap length itself is legal.
        wrap_mask = ((ADDR_W'(len) + ONE) << size) - ONE;

        case (btype)
            INCR:    next_addr = aligned + bytes;
            WRAP:    next_addr = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);
            default: next_addr = addr;
        endcase

        illegal = (size > 3'(LANE_W))
               || (btype == RSVD)
               || ((btype == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave memory: FIXED/INCR/WRAP bursts, narrow transfers,
// byte strobes, per-transaction IDs. Independent write and read FSMs
// share one storage array; contents survive reset.
// Ports:
//   aclk, aresetn                       clock, synchronous active-low reset
//   aw*  (id/addr/len/size/burst/valid) write address channel, awready out
//   w*   (data/strb/last/valid)         write data channel, wready out
//   b*   (id/resp/valid)                write response out, bready in
//   ar*  (id/addr/len/size/burst/valid) read address channel, arready out
//   r*   (id/data/resp/last/valid)      read data out, rready in
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, storing beats until counter reaches len
// W_RESP | bvalid high with final bresp, waiting for bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, one registered beat presented per handshake
module axi4_burst_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH_WORDS * STRB_W);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte lanes covered by a beat of the given size at the given lane offset.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [LANE_W-1:0] lane,
                                                    input logic [2:0] size);
        logic [LANE_W-1:0] lo;
        int                nb;
        lo = lane & ~(LANE_W'(bytes_from_size(size)) - LANE_W'(1));
        nb = int'(bytes_from_size(size));
        for (int i = 0; i < STRB_W; i++) begin
            lane_mask[i] = (i >= int'(lo)) && (i < int'(lo) + nb);
        end
    endfunction

    // ---------------- write side ----------------
    wr_state_t         w_state;
    logic [ADDR_W-1:0] w_addr, w_next;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_illegal;
    logic              w_beat, w_last_beat, w_oob, w_beat_err, w_we;
    logic [STRB_W-1:0] w_mask;
    logic [IDX_W-1:0]  w_idx;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_w_gen (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
        .next_addr(w_next), .illegal(w_illegal)
    );

    always_comb begin
        w_beat      = (w_state == W_DATA) && wvalid && wready;
        w_last_beat = (w_cnt == w_len);
        w_oob       = ({1'b0, w_addr} >= CAP);
        w_beat_err  = (wlast != w_last_beat) || w_oob;
        w_mask      = lane_mask(w_addr[LANE_W-1:0], w_size);
        w_idx       = IDX_W'(w_addr >> LANE_W);
        // A beat landing on the reset edge belongs to an abandoned burst.
        w_we        = w_beat && !w_illegal && !w_oob && aresetn;
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i] && w_mask[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || w_beat_err || w_illegal) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_err <= w_err || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= OKAY;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr, r_next, r_look, g_addr;
    logic [7:0]        r_len, r_cnt, g_len;
    logic [2:0]        r_size, g_size;
    logic [1:0]        r_burst, g_burst;
    logic              r_illegal, r_bad;
    logic [DATA_W-1:0] r_word;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_r_gen (
        .addr(g_addr), .len(g_len), .size(g_size), .burst(g_burst),
        .next_addr(r_next), .illegal(r_illegal)
    );

    // In idle the generator checks the incoming AR fields so the first beat
    // can be fetched on the handshake edge; afterwards it walks the burst.
    always_comb begin
        g_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
        g_len   = (r_state == R_IDLE) ? arlen   : r_len;
        g_size  = (r_state == R_IDLE) ? arsize  : r_size;
        g_burst = (r_state == R_IDLE) ? arburst : r_burst;
        r_look  = (r_state == R_IDLE) ? araddr  : r_next;
        r_bad   = r_illegal || ({1'b0, r_look} >= CAP);
        r_word  = mem[IDX_W'(r_look >> LANE_W)];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        rdata   <= r_bad ? '0 : r_word;
                        rresp   <= r_bad ? SLVERR : OKAY;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            rdata   <= '0;
                            rresp   <= OKAY;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_cnt  <= r_cnt + 8'd1;
                            rlast  <= ((r_cnt + 8'd1) == r_len);
                            rdata  <= r_bad ? '0 : r_word;
                            rresp  <= r_bad ? SLVERR : OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
module tb_axi4_burst_slave_mem;

    logic        aclk, aresetn;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi4_burst_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH_WORDS(1024)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];

    // ---------------- monitor / scoreboard ----------------
    logic        b_hold = 1'b0, r_hold = 1'b0, r_cont = 1'b0;
    logic [1:0]  pb_resp, pr_resp;
    logic [3:0]  pb_id, pr_id;
    logic [31:0] pr_data;
    logic        pr_last;
    b_exp_t      be;
    r_exp_t      re;

    always @(negedge aclk) begin
        if (!aresetn) begin
            b_hold = 1'b0;
            r_hold = 1'b0;
            r_cont = 1'b0;
        end else begin
            if (b_hold) begin
                chk("b_stable_valid", bvalid, 1'b1);
                chk("b_stable_resp", bresp, pb_resp);
                chk("b_stable_id", bid, pb_id);
            end
            if (bvalid && bready) begin
                chk("b_expected", bq.size() != 0, 1'b1);
                if (bq.size() != 0) begin
                    be = bq.pop_front();
                    chk("bid", bid, be.id);
                    chk("bresp", bresp, be.resp);
                end
            end
            b_hold  = bvalid && !bready;
            pb_resp = bresp;
            pb_id   = bid;

            if (r_cont) chk("r_back_to_back", rvalid, 1'b1);
            if (r_hold) begin
                chk("r_stable_valid", rvalid, 1'b1);
                chk("r_stable_data", rdata, pr_data);
                chk("r_stable_resp", rresp, pr_resp);
                chk("r_stable_last", rlast, pr_last);
                chk("r_stable_id", rid, pr_id);
            end
            if (rvalid && rready) begin
                chk("r_expected", rq.size() != 0, 1'b1);
                if (rq.size() != 0) begin
                    re = rq.pop_front();
                    chk("rid", rid, re.id);
                    chk("rdata", rdata, re.data);
                    chk("rresp", rresp, re.resp);
                    chk("rlast", rlast, re.last);
                end
            end
            r_cont  = rvalid && rready && !rlast;
            r_hold  = rvalid && !rready;
            pr_data = rdata;
            pr_resp = rresp;
            pr_last = rlast;
            pr_id   = rid;
        end
    end

    // ---------------- rready driver ----------------
    logic r_toggle = 1'b0;
    initial begin
        rready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            rready = r_toggle ? ~rready : 1'b1;
        end
    end

    // ---------------- stimulus tasks ----------------
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    logic        wl[16];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        chk("aw_handshake", awready, 1'b1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 50) begin tick(); n++; end
        chk("w_handshake", wready, 1'b1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        chk("ar_handshake", arready, 1'b1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic finish_b(input logic [3:0] id, input logic [1:0] resp, input int delay);
        b_exp_t e;
        int n = 0;
        e.id = id; e.resp = resp;
        bq.push_back(e);
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("bvalid_seen", bvalid, 1'b1);
        for (int i = 0; i < delay; i++) begin
            chk("awready_low_in_resp", awready, 1'b0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_drained", bq.size(), 0);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [1:0] resp, input int delay);
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) send_w(wd[i], ws[i], wl[i]);
        finish_b(id, resp, delay);
    endtask

    task automatic fill(input logic [31:0] d0, input logic [31:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = d0 + step * i;
            ws[i] = 4'hF;
            wl[i] = (i == n - 1);
        end
    endtask

    task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                         input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic wait_r();
        int n = 0;
        while (rq.size() != 0 && n < 200) begin tick(); n++; end
        chk("r_drained", rq.size(), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;

        repeat (3) tick();
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        aresetn = 1'b1;
        tick();
        chk("awready_after_rst", awready, 1'b1);
        chk("arready_after_rst", arready, 1'b1);

        // INCR write then INCR read back-to-back
        fill(32'h0000_00A0, 32'h1, 4);
        write_burst(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, 2'b00, 0);
        exp_r(4'h5, 32'h0000_00A0, 2'b00, 1'b0);
        exp_r(4'h5, 32'h0000_00A1, 2'b00, 1'b0);
        exp_r(4'h5, 32'h0000_00A2, 2'b00, 1'b0);
        exp_r(4'h5, 32'h0000_00A3, 2'b00, 1'b1);
        send_ar(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
        wait_r();

        // WRAP read 0x38 -> 0x38, 0x3C, 0x30, 0x34
        fill(32'h0000_0030, 32'h4, 4);
        write_burst(4'h1, 32'h30, 8'd3, 3'd2, 2'b01, 2'b00, 0);
        exp_r(4'h2, 32'h0000_0038, 2'b00, 1'b0);
        exp_r(4'h2, 32'h0000_003C, 2'b00, 1'b0);
        exp_r(4'h2, 32'h0000_0030, 2'b00, 1'b0);
        exp_r(4'h2, 32'h0000_0034, 2'b00, 1'b1);
        send_ar(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_r();

        // Narrow byte writes at 0x101 and 0x102
        wd[0] = 32'hEEEE_55EE; ws[0] = 4'b0010; wl[0] = 1'b0;
        wd[1] = 32'hEE66_EEEE; ws[1] = 4'b0100; wl[1] = 1'b1;
        write_burst(4'h4, 32'h101, 8'd1, 3'd0, 2'b01, 2'b00, 0);
        exp_r(4'h4, 32'h0066_55A0, 2'b00, 1'b1);
        send_ar(4'h4, 32'h100, 8'd0, 3'd2, 2'b01);
        wait_r();

        // Reserved burst: SLVERR and memory untouched
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        write_burst(4'h6, 32'h104, 8'd0, 3'd2, 2'b11, 2'b10, 0);
        exp_r(4'h6, 32'h0000_00A1, 2'b00, 1'b1);
        send_ar(4'h6, 32'h104, 8'd0, 3'd2, 2'b01);
        wait_r();

        // Early wlast on beat 2 of 4
        fill(32'h0000_0200, 32'h1, 4);
        wl[1] = 1'b1;
        write_burst(4'h7, 32'h200, 8'd3, 3'd2, 2'b01, 2'b10, 0);

        // Read crossing the end of storage
        fill(32'h1234_5678, 32'h0, 1);
        write_burst(4'h8, 32'hFFC, 8'd0, 3'd2, 2'b01, 2'b00, 0);
        exp_r(4'h9, 32'h1234_5678, 2'b00, 1'b0);
        exp_r(4'h9, 32'h0000_0000, 2'b10, 1'b1);
        send_ar(4'h9, 32'hFFC, 8'd1, 3'd2, 2'b01);
        wait_r();

        // Backpressure on B and R
        fill(32'hBB00_0000, 32'h1, 2);
        write_burst(4'hA, 32'h300, 8'd1, 3'd2, 2'b01, 2'b00, 5);
        chk("awready_after_b", awready, 1'b1);
        r_toggle = 1'b1;
        exp_r(4'hB, 32'hBB00_0000, 2'b00, 1'b0);
        exp_r(4'hB, 32'hBB00_0001, 2'b00, 1'b1);
        send_ar(4'hB, 32'h300, 8'd1, 3'd2, 2'b01);
        wait_r();
        r_toggle = 1'b0;

        // Reset in the middle of an 8-beat write
        send_aw(4'hC, 32'h400, 8'd7, 3'd2, 2'b01);
        send_w(32'h1111_1111, 4'hF, 1'b0);
        send_w(32'h2222_2222, 4'hF, 1'b0);
        aresetn = 1'b0;
        tick();
        chk("midrst_awready", awready, 1'b0);
        chk("midrst_wready", wready, 1'b0);
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_arready", arready, 1'b0);
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_bid", bid, 4'h0);
        aresetn = 1'b1;
        tick();
        chk("midrst_awready_after", awready, 1'b1);
        chk("midrst_wready_after", wready, 1'b0);
        exp_r(4'hD, 32'h1111_1111, 2'b00, 1'b0);
        exp_r(4'hD, 32'h2222_2222, 2'b00, 1'b1);
        send_ar(4'hD, 32'h400, 8'd1, 3'd2, 2'b01);
        wait_r();
        repeat (3) tick();
        chk("no_stray_b", bq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
